// File: rtl/layer_draw_scheduler_if.sv
// layer_draw_scheduler_if: frame handshake, engine bank buses and VGA write port
//   frameReq/layerEn/frameDone/busy/err : game FSM side
//   layerStart/layerDone/xIn/yIn/cIn/wIn : draw engine bank, slot i at [i*W +: W]
//   x/y/colour/writeEn                   : registered pixel to VGA adapter
interface layer_draw_scheduler_if #(
    parameter int N_LAYERS = 4,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int C_W      = 8
);
    logic                    frameReq;
    logic [N_LAYERS-1:0]     layerEn;
    logic [N_LAYERS-1:0]     layerStart;
    logic [N_LAYERS-1:0]     layerDone;
    logic [N_LAYERS*X_W-1:0] xIn;
    logic [N_LAYERS*Y_W-1:0] yIn;
    logic [N_LAYERS*C_W-1:0] cIn;
    logic [N_LAYERS-1:0]     wIn;
    logic [X_W-1:0]          x;
    logic [Y_W-1:0]          y;
    logic [C_W-1:0]          colour;
    logic                    writeEn;
    logic                    busy;
    logic                    frameDone;
    logic                    err;
    modport master (
        input  frameReq, layerEn, layerDone, xIn, yIn, cIn, wIn,
        output layerStart, x, y, colour, writeEn, busy, frameDone, err
    );
    modport slave (
        output frameReq, layerEn, layerDone, xIn, yIn, cIn, wIn,
        input  layerStart, x, y, colour, writeEn, busy, frameDone, err
    );
endinterface

// File: rtl/layer_draw_scheduler.sv
// layer_draw_scheduler: runs enabled draw engines in slot order onto one VGA write port
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : layer_draw_scheduler_if.master (frame handshake, engine bank, VGA pixel)
module layer_draw_scheduler #(
    parameter int                    N_LAYERS   = 4,
    parameter int                    X_W        = 8,
    parameter int                    Y_W        = 7,
    parameter int                    C_W        = 8,
    parameter logic [C_W-1:0]        KEY_COLOUR = 8'h09,
    parameter logic [N_LAYERS-1:0]   TRANSP     = 4'b1110,
    parameter int                    TIMEOUT    = 20000,
    parameter int                    TO_W       = 16
) (
    input  logic clk,
    input  logic resetn,
    layer_draw_scheduler_if.master bus
);
    localparam int IDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, NEXT, DONE} state_t;
    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_LAYERS-1:0] mask_q, mask_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [C_W-1:0]      colour_q, colour_d;
    logic                we_q, we_d;
    logic [IDX_W:0]      first, after;
    logic [C_W-1:0]      c_sel;
    // {found, index} of the lowest set bit of m at position lo or above
    function automatic logic [IDX_W:0] lowest_from(input logic [N_LAYERS-1:0] m, input int lo);
        lowest_from = '0;
        for (int i = N_LAYERS - 1; i >= 0; i--)
            if (i >= lo && m[i]) lowest_from = {1'b1, IDX_W'(i)};
    endfunction
    assign first = lowest_from(bus.layerEn, 0);
    assign after = lowest_from(mask_q, int'(idx_q) + 1);
    assign c_sel = bus.cIn[idx_q*C_W +: C_W];
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        we_d     = 1'b0;
        case (state_q)
            IDLE: if (bus.frameReq) begin
                mask_d  = bus.layerEn;
                err_d   = 1'b0;
                idx_d   = first[IDX_W-1:0];
                state_d = first[IDX_W] ? LAUNCH : DONE;
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                x_d      = bus.xIn[idx_q*X_W +: X_W];
                y_d      = bus.yIn[idx_q*Y_W +: Y_W];
                colour_d = c_sel;
                we_d     = bus.wIn[idx_q] & ~(TRANSP[idx_q] & (c_sel == KEY_COLOUR));
                cnt_d    = cnt_q + 1'b1;
                // done wins over a coincident timeout, so err only flags a true hang
                if (bus.layerDone[idx_q]) state_d = NEXT;
                else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                idx_d   = after[IDX_W] ? after[IDX_W-1:0] : idx_q;
                state_d = after[IDX_W] ? LAUNCH : DONE;
            end
            DONE: state_d = bus.frameReq ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            we_q     <= we_d;
        end
    end
    assign bus.layerStart = (state_q == LAUNCH) ? (N_LAYERS'(1) << idx_q) : '0;
    assign bus.busy       = (state_q != IDLE) && (state_q != DONE);
    assign bus.frameDone  = (state_q == DONE);
    assign bus.err        = err_q;
    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.colour     = colour_q;
    assign bus.writeEn    = we_q;
endmodule

// File: tb/tb_layer_draw_scheduler.sv
// tb_layer_draw_scheduler: directed frame sequences against hand-computed scheduler outputs
module tb_layer_draw_scheduler;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    layer_draw_scheduler_if #(.N_LAYERS(4), .X_W(8), .Y_W(7), .C_W(8)) bus ();
    layer_draw_scheduler #(
        .N_LAYERS(4), .X_W(8), .Y_W(7), .C_W(8), .KEY_COLOUR(8'h09),
        .TRANSP(4'b1110), .TIMEOUT(16), .TO_W(16)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic pix(input int s, input logic [7:0] px, input logic [6:0] py,
                       input logic [7:0] pc, input logic pw);
        bus.xIn[s*8 +: 8] = px;
        bus.yIn[s*7 +: 7] = py;
        bus.cIn[s*8 +: 8] = pc;
        bus.wIn[s]        = pw;
    endtask
    initial begin
        bus.frameReq  = 1'b0;
        bus.layerEn   = '0;
        bus.layerDone = '0;
        bus.xIn       = '0;
        bus.yIn       = '0;
        bus.cIn       = '0;
        bus.wIn       = '0;
        step();
        step();
        chk("rst_we", 32'(bus.writeEn), 0);
        chk("rst_start", 32'(bus.layerStart), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.frameDone), 0);
        chk("rst_x", 32'(bus.x), 0);
        resetn = 1'b1;
        step();
        // frame 1: layers 0 and 1, three pixels each, key colour on both layers
        bus.frameReq = 1'b1;
        bus.layerEn  = 4'b0011;
        step();
        chk("f1_launch0", 32'(bus.layerStart), 32'b0001);
        chk("f1_busy", 32'(bus.busy), 1);
        bus.layerDone = 4'b0001;
        bus.layerEn   = 4'b1111;
        step();
        chk("f1_wait_start", 32'(bus.layerStart), 0);
        chk("f1_wait_we", 32'(bus.writeEn), 0);
        bus.layerDone = '0;
        pix(0, 8'd10, 7'd20, 8'h09, 1'b1);
        pix(1, 8'd99, 7'd99, 8'h55, 1'b1);
        step();
        chk("f1_p0_x", 32'(bus.x), 10);
        chk("f1_p0_y", 32'(bus.y), 20);
        chk("f1_p0_c", 32'(bus.colour), 32'h09);
        chk("f1_p0_we_key_opaque", 32'(bus.writeEn), 1);
        pix(0, 8'd11, 7'd21, 8'h33, 1'b1);
        step();
        chk("f1_p1_x", 32'(bus.x), 11);
        chk("f1_p1_we", 32'(bus.writeEn), 1);
        pix(0, 8'd12, 7'd22, 8'h34, 1'b1);
        bus.layerDone = 4'b0001;
        step();
        chk("f1_p2_x", 32'(bus.x), 12);
        chk("f1_p2_we", 32'(bus.writeEn), 1);
        bus.layerDone = '0;
        pix(0, 8'd0, 7'd0, 8'h00, 1'b0);
        step();
        chk("f1_next_we", 32'(bus.writeEn), 0);
        chk("f1_launch1", 32'(bus.layerStart), 32'b0010);
        step();
        chk("f1_wait1_start", 32'(bus.layerStart), 0);
        pix(1, 8'd40, 7'd50, 8'h07, 1'b1);
        step();
        chk("f1_q0_x", 32'(bus.x), 40);
        chk("f1_q0_we", 32'(bus.writeEn), 1);
        pix(1, 8'd41, 7'd51, 8'h09, 1'b1);
        step();
        chk("f1_q1_x", 32'(bus.x), 41);
        chk("f1_q1_c", 32'(bus.colour), 32'h09);
        chk("f1_q1_we_key_transp", 32'(bus.writeEn), 0);
        pix(1, 8'd42, 7'd52, 8'h0a, 1'b1);
        bus.layerDone = 4'b0010;
        step();
        chk("f1_q2_x", 32'(bus.x), 42);
        chk("f1_q2_we", 32'(bus.writeEn), 1);
        bus.layerDone = '0;
        pix(1, 8'd0, 7'd0, 8'h00, 1'b0);
        step();
        chk("f1_done", 32'(bus.frameDone), 1);
        chk("f1_done_busy", 32'(bus.busy), 0);
        chk("f1_done_start_masked", 32'(bus.layerStart), 0);
        chk("f1_done_we", 32'(bus.writeEn), 0);
        chk("f1_done_x_hold", 32'(bus.x), 42);
        chk("f1_err", 32'(bus.err), 0);
        step();
        chk("f1_hold_done", 32'(bus.frameDone), 1);
        bus.frameReq = 1'b0;
        step();
        chk("f1_idle_done", 32'(bus.frameDone), 0);
        chk("f1_idle_busy", 32'(bus.busy), 0);
        // frame 2: empty mask goes straight to DONE
        bus.layerEn  = 4'b0000;
        bus.frameReq = 1'b1;
        step();
        chk("f2_done", 32'(bus.frameDone), 1);
        chk("f2_start", 32'(bus.layerStart), 0);
        chk("f2_busy", 32'(bus.busy), 0);
        bus.frameReq = 1'b0;
        step();
        chk("f2_idle", 32'(bus.frameDone), 0);
        // frame 3: sparse mask 1010, foreign done ignored, no wrap after slot 3
        bus.layerEn  = 4'b1010;
        bus.frameReq = 1'b1;
        step();
        chk("f3_launch1", 32'(bus.layerStart), 32'b0010);
        bus.frameReq = 1'b0;
        step();
        bus.layerDone = 4'b1000;
        step();
        chk("f3_foreign_done_busy", 32'(bus.busy), 1);
        chk("f3_foreign_done_start", 32'(bus.layerStart), 0);
        bus.layerDone = 4'b0010;
        step();
        bus.layerDone = '0;
        step();
        chk("f3_launch3", 32'(bus.layerStart), 32'b1000);
        step();
        pix(3, 8'd7, 7'd8, 8'h09, 1'b1);
        bus.layerDone = 4'b1000;
        step();
        chk("f3_key_l3_we", 32'(bus.writeEn), 0);
        chk("f3_key_l3_x", 32'(bus.x), 7);
        bus.layerDone = '0;
        pix(3, 8'd0, 7'd0, 8'h00, 1'b0);
        step();
        chk("f3_done_no_wrap", 32'(bus.frameDone), 1);
        chk("f3_done_start", 32'(bus.layerStart), 0);
        step();
        chk("f3_idle", 32'(bus.frameDone), 0);
        // frame 4: layer 1 hangs, times out after 16 WAIT cycles, layer 2 follows
        bus.layerEn  = 4'b0110;
        bus.frameReq = 1'b1;
        step();
        chk("f4_launch1", 32'(bus.layerStart), 32'b0010);
        step();
        for (int i = 0; i < 15; i++) step();
        chk("f4_pre_to_err", 32'(bus.err), 0);
        chk("f4_pre_to_busy", 32'(bus.busy), 1);
        step();
        chk("f4_to_err", 32'(bus.err), 1);
        step();
        chk("f4_launch2", 32'(bus.layerStart), 32'b0100);
        step();
        bus.layerDone = 4'b0100;
        step();
        bus.layerDone = '0;
        step();
        chk("f4_done", 32'(bus.frameDone), 1);
        chk("f4_err_sticky", 32'(bus.err), 1);
        bus.frameReq = 1'b0;
        step();
        chk("f4_idle_err", 32'(bus.err), 1);
        // frame 5: done coincides with timeout cycle, err cleared at accept and stays 0
        bus.layerEn  = 4'b0010;
        bus.frameReq = 1'b1;
        step();
        chk("f5_err_clear", 32'(bus.err), 0);
        chk("f5_launch1", 32'(bus.layerStart), 32'b0010);
        step();
        for (int i = 0; i < 15; i++) step();
        bus.layerDone = 4'b0010;
        step();
        bus.layerDone = '0;
        chk("f5_done_beats_to", 32'(bus.err), 0);
        step();
        chk("f5_done", 32'(bus.frameDone), 1);
        chk("f5_done_err", 32'(bus.err), 0);
        bus.frameReq = 1'b0;
        step();
        // frame 6: asynchronous reset during layer 1 WAIT
        bus.layerEn  = 4'b0011;
        bus.frameReq = 1'b1;
        step();
        step();
        bus.layerDone = 4'b0001;
        step();
        bus.layerDone = '0;
        step();
        chk("f6_launch1", 32'(bus.layerStart), 32'b0010);
        bus.frameReq = 1'b0;
        step();
        pix(1, 8'd77, 7'd66, 8'h44, 1'b1);
        step();
        chk("f6_pre_rst_we", 32'(bus.writeEn), 1);
        chk("f6_pre_rst_x", 32'(bus.x), 77);
        #2 resetn = 1'b0;
        #1;
        chk("f6_rst_we", 32'(bus.writeEn), 0);
        chk("f6_rst_x", 32'(bus.x), 0);
        chk("f6_rst_busy", 32'(bus.busy), 0);
        chk("f6_rst_start", 32'(bus.layerStart), 0);
        step();
        resetn = 1'b1;
        step();
        step();
        chk("f6_post_start", 32'(bus.layerStart), 0);
        chk("f6_post_busy", 32'(bus.busy), 0);
        chk("f6_post_done", 32'(bus.frameDone), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
